// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    // Fetch stage side: issues requests, receives completions.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side: accepts requests, returns completions.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, wait-state tolerant imem handshake,
// one-entry hold buffer for fetches completed under stall, and redirect handling that lets an
// in-flight request finish before its data is thrown away.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallF,
    input  logic                FlushD,
    input  logic                PCSrcE,
    input  logic [XLEN-1:0]     PCTargetE,
    fetch_stage_if.master       imem,
    output logic [XLEN-1:0]     PCF,
    output logic [31:0]         InstrD,
    output logic [XLEN-1:0]     PCD,
    output logic [XLEN-1:0]     PCPlus4D,
    output logic                ValidD
);

    localparam logic [31:0]     Nop        = 32'h0000_0013;
    localparam logic [XLEN-1:0] ResetPcAln = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] Four       = XLEN'(4);

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StHold    = 2'd1,
        StDiscard = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [31:0]     buf_q, buf_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4d_q, pcp4d_d;
    logic            valid_q, valid_d;

    logic            done;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    // What the state machine would like IF/ID to do this edge, before flush/stall override.
    logic            ifid_load;
    logic [31:0]     ifid_instr;

    assign target   = {PCTargetE[XLEN-1:2], 2'b00};
    assign pc_plus4 = pc_q + Four;

    // Request outputs: no request in HOLD or while reset is high; DISCARD keeps the old address.
    always_comb begin
        imem.imem_req  = !reset && (state_q != StHold);
        imem.imem_addr = (state_q == StDiscard) ? pend_q : pc_q;
    end

    assign done = imem.imem_req && imem.imem_rvalid;

    // Fetch FSM next-state, PC and buffer updates, plus the requested IF/ID action.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        buf_d      = buf_q;
        ifid_load  = 1'b0;
        ifid_instr = imem.imem_rdata;

        unique case (state_q)
            StFetch: begin
                if (done) begin
                    if (PCSrcE) begin
                        pc_d = target;
                    end else if (FlushD) begin
                        pc_d = pc_q;
                    end else if (StallF) begin
                        buf_d   = imem.imem_rdata;
                        state_d = StHold;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4;
                    end
                end else if (PCSrcE) begin
                    // Request still outstanding: must let it complete at its original address.
                    pend_d  = pc_q;
                    pc_d    = target;
                    state_d = StDiscard;
                end
            end
            StHold: begin
                if (PCSrcE) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (FlushD) begin
                    state_d = StFetch;
                end else if (!StallF) begin
                    ifid_load  = 1'b1;
                    ifid_instr = buf_q;
                    pc_d       = pc_plus4;
                    state_d    = StFetch;
                end
            end
            StDiscard: begin
                if (PCSrcE) begin
                    pc_d = target;
                end
                if (done) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // IF/ID next value: flush beats stall beats the state machine's load/bubble.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = Nop;
            valid_d = 1'b0;
        end else if (StallF) begin
            instr_d = instr_q;
        end else if (ifid_load) begin
            instr_d = ifid_instr;
            pcd_d   = pc_q;
            pcp4d_d = pc_plus4;
            valid_d = 1'b1;
        end else begin
            instr_d = Nop;
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset also abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= ResetPcAln;
            pend_q  <= '0;
            buf_q   <= '0;
            instr_q <= Nop;
            pcd_q   <= '0;
            pcp4d_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4d_q <= pcp4d_d;
            valid_q <= valid_d;
        end
    end

    assign PCF      = pc_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4d_q;
    assign ValidD   = valid_q;

endmodule
